// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN / PC_STEP : datapath width and sequential fetch increment
//   NOP_INSTR      : canonical NOP (ADDI x0,x0,0)
//   RESET_VECTOR   : default first fetch address after reset
//   ifq_entry_t    : one fetch-queue entry {pc, instr}
//   word_align()   : clears the byte-offset bits of an address
package rv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic DEPTH x 64-bit circular buffer holding {pc, instr} entries.
//   push/push_data : write one entry at the tail
//   pop            : retire the head entry (ignored while empty)
//   flush          : discard everything; overrides push and pop
//   head_data      : current head entry (stale when empty)
//   count/full/empty : occupancy status
module ifq_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output ifq_entry_t               head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]  PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    ifq_entry_t     mem_r [DEPTH];
    logic [AW-1:0]  head_r;
    logic [AW-1:0]  tail_r;
    logic [AW:0]    count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == DEPTH_L);
    assign count     = count_r;
    assign head_data = mem_r[head_r];

    // Qualify requests: flush wins; a push into a full buffer is only legal alongside a pop.
    always_comb begin
        do_pop_s  = pop & ~empty & ~flush;
        do_push_s = push & ~flush & (~full | do_pop_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (do_pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head never exposes undefined data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
            end
        end else if (do_push_s) begin
            mem_r[tail_r] <= push_data;
        end else begin
            mem_r[tail_r] <= mem_r[tail_r];
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue feeding the decode unit.
//   IM_req/IM_addr/IM_rdata : sequential fetch to a 1-cycle-latency instruction memory
//   EX_redirect/EX_target   : branch/jump redirect; flushes queue and restarts fetch
//   DU_ready                : decode consumes the head entry
//   IFQ_valid/IFQ_Instr/IFQ_PC : head of queue (NOP_INSTR / 0 when empty)
module instr_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = rv_pkg::RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        IM_req,
    output logic [31:0] IM_addr,
    input  logic [31:0] IM_rdata,
    input  logic        EX_redirect,
    input  logic [31:0] EX_target,
    input  logic        DU_ready,
    output logic        IFQ_valid,
    output logic [31:0] IFQ_Instr,
    output logic [31:0] IFQ_PC
);

    import rv_pkg::*;

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   inflight_pc_r;
    logic          inflight_r;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [AW:0]   count_s;
    logic [AW+1:0] occupancy_s;
    ifq_entry_t    head_s;
    ifq_entry_t    wr_entry_s;

    // Issue/push/pop decisions. A request is only issued when a slot is guaranteed
    // for its response, counting the one already in flight; pops give no credit.
    // rst_n gates the request so it drops immediately on an asynchronous reset.
    always_comb begin
        occupancy_s      = {1'b0, count_s} + {{(AW+1){1'b0}}, inflight_r};
        issue_s          = rst_n & ~EX_redirect & ~full_s & (occupancy_s < DEPTH_W);
        push_s           = inflight_r & ~EX_redirect;
        pop_s            = ~empty_s & DU_ready & ~EX_redirect;
        wr_entry_s.pc    = inflight_pc_r;
        wr_entry_s.instr = IM_rdata;
    end

    // Fetch PC and in-flight tracking; a redirect kills the outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else if (EX_redirect) begin
            fetch_pc_r    <= word_align(EX_target);
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + PC_STEP;
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            fetch_pc_r    <= fetch_pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (wr_entry_s),
        .pop       (pop_s),
        .flush     (EX_redirect),
        .head_data (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign IM_req  = issue_s;
    assign IM_addr = fetch_pc_r;

    // Head presentation; an empty queue shows a NOP at PC 0.
    always_comb begin
        IFQ_valid = ~empty_s;
        if (empty_s) begin
            IFQ_Instr = NOP_INSTR;
            IFQ_PC    = 32'h0000_0000;
        end else begin
            IFQ_Instr = head_s.instr;
            IFQ_PC    = head_s.pc;
        end
    end

endmodule
